qlf_k6n10_bram_sdp: RTL and testbench

Parametrised simple-dual-port block RAM simulation/whitebox model for the qlf_k6n10 fabric, superseding the fixed 4096x32 dual-port RAM. Adds configurable width and depth, per-byte write enables, a selectable read-during-write mode, a hardware clear sequencer run after reset, and a read-data valid flag. The techmap flow instantiates it for inferred memories, and it is used directly in fabric-level simulation.

---
 rtl/qlf_k6n10_bram_pkg.sv | 17 +
 rtl/qlf_k6n10_bram_sdp_if.sv | 25 ++
 rtl/qlf_k6n10_bram_clear_fsm.sv | 51 +++++
 rtl/qlf_k6n10_bram_sdp.sv | 151 +++++++++++++++
 tb/tb_qlf_k6n10_bram_sdp.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/qlf_k6n10_bram_pkg.sv
// rtl/qlf_k6n10_bram_pkg.sv - shared constants, clear-FSM state type and parameter bounds for the SDP BRAM
package qlf_k6n10_bram_pkg;

    localparam int RDW_READ_OLD      = 0;
    localparam int RDW_WRITE_THROUGH = 1;

    localparam int DATA_WIDTH_MIN = 8;
    localparam int DATA_WIDTH_MAX = 64;
    localparam int ADDR_WIDTH_MIN = 4;
    localparam int ADDR_WIDTH_MAX = 14;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } bram_state_t;

endpackage

// File: rtl/qlf_k6n10_bram_sdp_if.sv
// rtl/qlf_k6n10_bram_sdp_if.sv - write/read port bundle of the SDP BRAM
interface qlf_k6n10_bram_sdp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic                    wen;
    logic [DATA_WIDTH/8-1:0] be;
    logic [ADDR_WIDTH-1:0]   waddr;
    logic [DATA_WIDTH-1:0]   d_in;
    logic                    ren;
    logic [ADDR_WIDTH-1:0]   raddr;
    logic [DATA_WIDTH-1:0]   d_out;
    logic                    d_valid;
    logic                    busy;

    modport master (
        output wen, be, waddr, d_in, ren, raddr,
        input  d_out, d_valid, busy
    );

    modport slave (
        input  wen, be, waddr, d_in, ren, raddr,
        output d_out, d_valid, busy
    );
endinterface

// File: rtl/qlf_k6n10_bram_clear_fsm.sv
// rtl/qlf_k6n10_bram_clear_fsm.sv - post-reset clear sequencer: walks clr_addr over the array while busy
module qlf_k6n10_bram_clear_fsm
    import qlf_k6n10_bram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);
    localparam bram_state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

    bram_state_t           state;
    bram_state_t           state_next;
    logic [ADDR_WIDTH-1:0] addr_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RESET_STATE;
            clr_addr <= '0;
        end else begin
            state    <= state_next;
            clr_addr <= addr_next;
        end
    end

    always_comb begin
        state_next = state;
        addr_next  = clr_addr;
        clr_we     = 1'b0;
        case (state)
            CLEAR: begin
                clr_we    = 1'b1;
                addr_next = clr_addr + 1'b1;
                // Leave on the edge that writes the last word
                if (clr_addr == {ADDR_WIDTH{1'b1}}) begin
                    state_next = READY;
                end
            end
            default: begin
                state_next = READY;
            end
        endcase
    end

    assign busy = (state == CLEAR);

endmodule

// File: rtl/qlf_k6n10_bram_sdp.sv
// rtl/qlf_k6n10_bram_sdp.sv - parametrised simple-dual-port BRAM with byte enables, RDW mode and post-reset clear
// QLF_K6N10_BRAM_OUTREG_EN adds an output pipeline register (read latency 2).
module qlf_k6n10_bram_sdp
    import qlf_k6n10_bram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int RDW_MODE       = RDW_READ_OLD,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    qlf_k6n10_bram_sdp_if.slave  bus
);
    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int DEPTH     = 1 << ADDR_WIDTH;

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_bad_data_width
        $error("qlf_k6n10_bram_sdp: DATA_WIDTH %0d out of range", DATA_WIDTH);
    end
    if (ADDR_WIDTH < ADDR_WIDTH_MIN || ADDR_WIDTH > ADDR_WIDTH_MAX) begin : g_bad_addr_width
        $error("qlf_k6n10_bram_sdp: ADDR_WIDTH %0d out of range", ADDR_WIDTH);
    end
    if (RDW_MODE != RDW_READ_OLD && RDW_MODE != RDW_WRITE_THROUGH) begin : g_bad_rdw_mode
        $error("qlf_k6n10_bram_sdp: RDW_MODE %0d out of range", RDW_MODE);
    end
    if (CLEAR_ON_RESET != 0 && CLEAR_ON_RESET != 1) begin : g_bad_clear
        $error("qlf_k6n10_bram_sdp: CLEAR_ON_RESET %0d out of range", CLEAR_ON_RESET);
    end

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NUM_BYTES-1:0]  byte_en
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (byte_en[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic                  busy;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    qlf_k6n10_bram_clear_fsm #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .CLEAR_ON_RESET(CLEAR_ON_RESET)
    ) u_clear_fsm (
        .clk     (clk),
        .rst_n   (rst_n),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  user_we;
    logic                  rd_accept;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NUM_BYTES-1:0]  wr_be;

    // User ports are dropped entirely while the clear sequence owns the array
    assign user_we   = bus.wen && !busy;
    assign rd_accept = bus.ren && !busy;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.waddr;
        wr_data = bus.d_in;
        wr_be   = bus.be;
        if (clr_we) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
            wr_data = '0;
            wr_be   = '1;
        end else if (user_we) begin
            wr_en   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    logic [DATA_WIDTH-1:0] rd_old;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rdw_hit;

    assign rd_old  = mem[bus.raddr];
    assign rdw_hit = user_we && (bus.waddr == bus.raddr);

    always_comb begin
        rd_word = rd_old;
        if (RDW_MODE == RDW_WRITE_THROUGH && rdw_hit) begin
            rd_word = merge_bytes(rd_old, bus.d_in, bus.be);
        end
    end

    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_accept;
            if (rd_accept) begin
                rd_data_q <= rd_word;
            end
        end
    end

`ifdef QLF_K6N10_BRAM_OUTREG_EN
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= rd_data_q;
            out_valid_q <= rd_valid_q;
        end
    end

    assign bus.d_out   = out_data_q;
    assign bus.d_valid = out_valid_q;
`else
    assign bus.d_out   = rd_data_q;
    assign bus.d_valid = rd_valid_q;
`endif

    assign bus.busy = busy;

endmodule

// File: tb/tb_qlf_k6n10_bram_sdp.sv
// tb/tb_qlf_k6n10_bram_sdp.sv - self-checking bench for qlf_k6n10_bram_sdp (read-old and write-through instances)
module tb_qlf_k6n10_bram_sdp;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
`ifdef QLF_K6N10_BRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wen = 1'b0;
    logic        ren = 1'b0;
    logic [3:0]  be = '0;
    logic [AW-1:0] waddr = '0;
    logic [AW-1:0] raddr = '0;
    logic [DW-1:0] d_in = '0;

    always #5 clk = ~clk;

    qlf_k6n10_bram_sdp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
    qlf_k6n10_bram_sdp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

    assign bus0.wen = wen;  assign bus1.wen = wen;
    assign bus0.ren = ren;  assign bus1.ren = ren;
    assign bus0.be = be;    assign bus1.be = be;
    assign bus0.waddr = waddr; assign bus1.waddr = waddr;
    assign bus0.raddr = raddr; assign bus1.raddr = raddr;
    assign bus0.d_in = d_in;   assign bus1.d_in = d_in;

    qlf_k6n10_bram_sdp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    qlf_k6n10_bram_sdp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    int checks = 0;
    int errors = 0;

    // Reference: array contents, clear cycles remaining, and the visible result per read mode
    logic [DW-1:0] ref_mem [DEPTH];
    int            clear_left;
    logic          res_v;
    logic [DW-1:0] res_d [2];
    logic          out_v;
    logic [DW-1:0] out_d [2];

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n, input logic [3:0] m);
        logic [DW-1:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic          nv;
        logic [DW-1:0] nd [2];
        nv = 1'b0;
        nd[0] = res_d[0];
        nd[1] = res_d[1];
        if (clear_left > 0) begin
            clear_left--;
        end else begin
            if (ren) begin
                nv = 1'b1;
                nd[0] = ref_mem[raddr];
                nd[1] = (wen && raddr == waddr) ? merge(ref_mem[raddr], d_in, be) : ref_mem[raddr];
            end
            if (wen) ref_mem[waddr] = merge(ref_mem[waddr], d_in, be);
        end
        if (LAT == 2) begin
            out_v = res_v; out_d[0] = res_d[0]; out_d[1] = res_d[1];
            res_v = nv;    res_d[0] = nd[0];    res_d[1] = nd[1];
        end else begin
            res_v = nv;    res_d[0] = nd[0];    res_d[1] = nd[1];
            out_v = res_v; out_d[0] = res_d[0]; out_d[1] = res_d[1];
        end
        @(posedge clk);
        @(negedge clk);
        chk("d_out_old",   bus0.d_out,   out_d[0]);
        chk("d_out_wt",    bus1.d_out,   out_d[1]);
        chk("d_valid_old", {31'b0, bus0.d_valid}, {31'b0, out_v});
        chk("d_valid_wt",  {31'b0, bus1.d_valid}, {31'b0, out_v});
        chk("busy_old",    {31'b0, bus0.busy}, {31'b0, clear_left > 0});
        chk("busy_wt",     {31'b0, bus1.busy}, {31'b0, clear_left > 0});
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_d_out",   bus0.d_out, 32'h0);
        chk("rst_d_valid", {31'b0, bus0.d_valid}, 32'h0);
        chk("rst_busy",    {31'b0, bus0.busy}, 32'h1);
        chk("rst_busy_wt", {31'b0, bus1.busy}, 32'h1);
        clear_left = DEPTH;
        res_v = 1'b0; out_v = 1'b0;
        for (int i = 0; i < 2; i++) begin res_d[i] = '0; out_d[i] = '0; end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_clear();
        int n;
        n = 0;
        while (bus0.busy && n < 40) begin
            tick();
            n++;
        end
        chk("clear_len", n, DEPTH);
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] m);
        wen = 1'b1; ren = 1'b0; waddr = a; d_in = d; be = m;
        tick();
        wen = 1'b0;
    endtask

    task automatic read_settle(input logic [AW-1:0] a);
        wen = 1'b0; ren = 1'b1; raddr = a;
        tick();
        ren = 1'b0;
        repeat (LAT - 1) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        apply_reset();

        // Writes issued during the clear must be dropped
        wen = 1'b1; waddr = 4'd2; d_in = 32'hDEADBEEF; be = 4'hF;
        wait_clear();
        wen = 1'b0;

        for (int a = 0; a < DEPTH; a++) begin
            ren = 1'b1; raddr = a[AW-1:0];
            tick();
        end
        ren = 1'b0;
        repeat (LAT) tick();
        read_settle(4'd2);
        chk("busy_gate_addr2", bus0.d_out, 32'h0);

        write(4'd5, 32'hAABBCCDD, 4'b1111);
        write(4'd5, 32'h11223344, 4'b0101);
        read_settle(4'd5);
        chk("byte_en_addr5", bus0.d_out, 32'hAA22CC44);

        write(4'd3, 32'h12345678, 4'hF);
        wen = 1'b1; ren = 1'b1; waddr = 4'd3; raddr = 4'd3; d_in = 32'hFFFF0000; be = 4'b1100;
        tick();
        wen = 1'b0; ren = 1'b0;
        repeat (LAT - 1) tick();
        chk("rdw_read_old",      bus0.d_out, 32'h12345678);
        chk("rdw_write_through", bus1.d_out, 32'hFFFF5678);
        read_settle(4'd3);
        chk("rdw_after", bus0.d_out, 32'hFFFF5678);

        for (int n = 0; n < 400; n++) begin
            wen   = ($urandom_range(0, 2) != 0);
            ren   = ($urandom_range(0, 3) != 0);
            be    = 4'($urandom);
            waddr = AW'($urandom);
            raddr = (($urandom % 3) == 0) ? waddr : AW'($urandom);
            d_in  = $urandom;
            tick();
        end
        wen = 1'b0; ren = 1'b0;
        repeat (LAT) tick();

        // Abort the clear at clr_addr 9 and confirm a full restart
        apply_reset();
        repeat (9) tick();
        #2;
        apply_reset();
        wait_clear();
        for (int a = 0; a < DEPTH; a++) begin
            ren = 1'b1; raddr = a[AW-1:0];
            tick();
        end
        ren = 1'b0;
        repeat (LAT) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
